// File: rtl/pipe_seq_pkg.sv
// -----------------------------------------------------------------------------
// pipe_seq_pkg
//
// Shared definitions for the pipe_seq_ctrl slice:
//   REQ_ID_0 / REQ_ID_1 : requester index constants carried in each stage
//   PERF_W              : width of the optional performance counters
//   MAX_WIDTH           : widest payload a stage record can carry
//   stage_t             : one pipeline stage record {valid, id, data}
//   sat_inc()           : saturating increment used by the perf counters
//
// The stage record is sized for MAX_WIDTH because a package cannot follow a
// module parameter. Instances keep WIDTH <= MAX_WIDTH and use only the low
// WIDTH bits of the data field; the upper bits always hold zero.
// -----------------------------------------------------------------------------
package pipe_seq_pkg;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  localparam int PERF_W    = 16;
  localparam int MAX_WIDTH = 32;

  typedef struct packed {
    logic                 valid;
    logic                 id;
    logic [MAX_WIDTH-1:0] data;
  } stage_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
    logic [PERF_W-1:0] result;
    if (value == {PERF_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + PERF_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_seq_rr_arb.sv
// -----------------------------------------------------------------------------
// pipe_seq_rr_arb
//
// Two-way round-robin arbiter with its own last-grant register.
//
// Ports:
//   CLK          in   clock, rising edge
//   ASYNCRESETN  in   asynchronous active-low reset
//   valid[1:0]   in   requester valid bits, bit N = requester N
//   enable       in   acceptance allowed this cycle (pipeline advancing,
//                     no flush, not in reset)
//   ready[1:0]   out  one-hot (or zero) accept strobe per requester
//   grant_id     out  index of the requester that wins this cycle
//
// A lone valid requester always wins. When both are valid, the one that was
// not granted last wins. The last-grant register resets to requester 1 so
// the very first tie goes to requester 0, and it moves only when a beat is
// really accepted, so stalled or flushed cycles never skew the rotation.
// -----------------------------------------------------------------------------
module pipe_seq_rr_arb
  import pipe_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] ready,
  output logic       grant_id
);

  logic last_grant;
  logic grant_any;

  // Pick the winner from the current valids and the rotation pointer.
  always_comb begin
    grant_any = |valid;
    grant_id  = REQ_ID_0;
    case (valid)
      2'b01:   grant_id = REQ_ID_0;
      2'b10:   grant_id = REQ_ID_1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = REQ_ID_0;
    endcase
  end

  // Only the winner sees ready, and only when the pipeline can take a beat.
  always_comb begin
    ready    = 2'b00;
    ready[0] = enable && grant_any && (grant_id == REQ_ID_0);
    ready[1] = enable && grant_any && (grant_id == REQ_ID_1);
  end

  // Rotation pointer follows accepted beats only.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      last_grant <= REQ_ID_1;
    end else if (enable && grant_any) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_seq_ctrl
//
// Two-requester round-robin front end feeding a DEPTH-stage register
// pipeline. Each stage holds {valid, id, data}; the last stage drives the
// output port directly, so all outputs except the readys are registered.
//
// Parameters:
//   WIDTH  payload width (must not exceed pipe_seq_pkg::MAX_WIDTH)
//   DEPTH  number of stages, 1..8
//
// Ports:
//   CLK, ASYNCRESETN              clock and async active-low reset
//   req0_valid/req0_data/req0_ready   requester 0 handshake
//   req1_valid/req1_data/req1_ready   requester 1 handshake
//   flush                         drop every in-flight beat
//   out_valid/out_data/out_id     last-stage beat
//   out_ready                     downstream accepts the beat
//   busy                          any stage holds a beat
//
// Optional feature, macro PIPE_SEQ_CTRL_PERF_EN:
//   perf_grant0, perf_grant1      accepted beats per requester
//   perf_stall                    cycles with out_valid && !out_ready
//   All three saturate at all-ones, clear on reset, and ignore flush.
//
// The whole pipeline moves as one: when the output is blocked nothing
// shifts and nothing is accepted, so bubbles are preserved rather than
// collapsed.
// -----------------------------------------------------------------------------
module pipe_seq_ctrl
  import pipe_seq_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
)
(
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy
`ifdef PIPE_SEQ_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_grant0,
  output logic [PERF_W-1:0] perf_grant1,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  stage_t     stage_q [DEPTH];
  stage_t     load_stage;
  logic       advance;
  logic       arb_enable;
  logic [1:0] arb_ready;
  logic       grant_id;
  logic       accept;

  // Outputs come straight from the last stage register.
  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_id    = stage_q[DEPTH-1].id;
  assign out_data  = stage_q[DEPTH-1].data[WIDTH-1:0];

  // The pipeline moves unless the last stage is holding an unaccepted beat.
  // Reset is folded in so the readys are low for as long as reset is held,
  // not just after the first clock edge.
  assign advance    = !(out_valid && !out_ready);
  assign arb_enable = advance && !flush && ASYNCRESETN;

  pipe_seq_rr_arb u_arb (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .valid       ({req1_valid, req0_valid}),
    .enable      (arb_enable),
    .ready       (arb_ready),
    .grant_id    (grant_id)
  );

  assign req0_ready = arb_ready[0];
  assign req1_ready = arb_ready[1];
  assign accept     = |arb_ready;

  // Build the record stage 0 loads on an advancing edge: the granted beat,
  // or a bubble when nothing was accepted.
  always_comb begin
    load_stage       = '0;
    load_stage.valid = accept;
    if (accept) begin
      load_stage.id              = grant_id;
      load_stage.data[WIDTH-1:0] = (grant_id == REQ_ID_1) ? req1_data : req0_data;
    end
  end

  // Stage registers. Flush only clears the valid bits; the stale id/data
  // left behind are never observed because nothing reads them while invalid.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i].valid <= 1'b0;
      end
    end else if (advance) begin
      stage_q[0] <= load_stage;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // busy is the OR of every stage's valid bit.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | stage_q[i].valid;
    end
  end

`ifdef PIPE_SEQ_CTRL_PERF_EN
  logic [PERF_W-1:0] grant0_cnt;
  logic [PERF_W-1:0] grant1_cnt;
  logic [PERF_W-1:0] stall_cnt;

  // Counters track accepted beats and blocked-output cycles. Flush does not
  // touch them; only reset clears them.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (arb_ready[0]) begin
        grant0_cnt <= sat_inc(grant0_cnt);
      end
      if (arb_ready[1]) begin
        grant1_cnt <= sat_inc(grant1_cnt);
      end
      if (out_valid && !out_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign perf_grant0 = grant0_cnt;
  assign perf_grant1 = grant1_cnt;
  assign perf_stall  = stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_seq_ctrl
//
// Self-checking bench for pipe_seq_ctrl with WIDTH=2, DEPTH=2.
// A table of per-cycle vectors covers the basic beat, round-robin rotation,
// stall/resume, flush and rotation-after-flush. Hand-written sequences then
// cover a long stall (counter saturation when PIPE_SEQ_CTRL_PERF_EN is
// defined) and an asynchronous reset asserted between clock edges.
//
// Inputs are driven on the falling edge; outputs are sampled 2 time units
// later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_seq_ctrl;
  import pipe_seq_pkg::*;

  localparam int WIDTH   = 2;
  localparam int DEPTH   = 2;
  localparam int N_VECS  = 23;
`ifdef PIPE_SEQ_CTRL_PERF_EN
  localparam int STALL_N = 70000;
`else
  localparam int STALL_N = 3;
`endif

  logic             CLK;
  logic             ASYNCRESETN;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             out_ready;
  logic             busy;
`ifdef PIPE_SEQ_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_grant0;
  logic [PERF_W-1:0] perf_grant1;
  logic [PERF_W-1:0] perf_stall;
`endif

  typedef struct {
    logic       r0v;
    logic [1:0] d0;
    logic       r1v;
    logic [1:0] d1;
    logic       fl;
    logic       ordy;
    logic       e_r0r;
    logic       e_r1r;
    logic       e_ov;
    logic [1:0] e_od;
    logic       e_oid;
    logic       e_busy;
  } vec_t;

  vec_t vecs [N_VECS];
  int   checks_total  = 0;
  int   checks_passed = 0;

  pipe_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_ready   (out_ready),
    .busy        (busy)
`ifdef PIPE_SEQ_CTRL_PERF_EN
    ,
    .perf_grant0 (perf_grant0),
    .perf_grant1 (perf_grant1),
    .perf_stall  (perf_stall)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the run ever wanders.
  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports any disagreement.
  task automatic checkOutput(input string name, input int step,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h",
               name, step, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input vec_t v);
    req0_valid = v.r0v;
    req0_data  = v.d0;
    req1_valid = v.r1v;
    req1_data  = v.d1;
    flush      = v.fl;
    out_ready  = v.ordy;
  endtask

  task automatic setVec(input int i,
                        input int r0v, input int d0, input int r1v, input int d1,
                        input int fl, input int ordy,
                        input int e_r0r, input int e_r1r, input int e_ov,
                        input int e_od, input int e_oid, input int e_busy);
    vecs[i].r0v    = 1'(r0v);
    vecs[i].d0     = 2'(d0);
    vecs[i].r1v    = 1'(r1v);
    vecs[i].d1     = 2'(d1);
    vecs[i].fl     = 1'(fl);
    vecs[i].ordy   = 1'(ordy);
    vecs[i].e_r0r  = 1'(e_r0r);
    vecs[i].e_r1r  = 1'(e_r1r);
    vecs[i].e_ov   = 1'(e_ov);
    vecs[i].e_od   = 2'(e_od);
    vecs[i].e_oid  = 1'(e_oid);
    vecs[i].e_busy = 1'(e_busy);
  endtask

  initial begin
    //       i  r0v d0 r1v d1 fl ordy | r0r r1r ov od oid busy
    // single beat from requester 0, out two cycles later
    setVec( 0, 1, 1, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    setVec( 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1);
    setVec( 2, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 1);
    // requester 1 alone, rotation pointer now at 1
    setVec( 3, 0, 0, 1, 2, 0, 1,   0, 1, 0, 0, 0, 0);
    // both valid four cycles: grants 0,1,0,1
    setVec( 4, 1, 0, 1, 3, 0, 1,   1, 0, 0, 0, 0, 1);
    setVec( 5, 1, 1, 1, 2, 0, 1,   0, 1, 1, 2, 1, 1);
    setVec( 6, 1, 3, 1, 0, 0, 1,   1, 0, 1, 0, 0, 1);
    setVec( 7, 1, 2, 1, 1, 0, 1,   0, 1, 1, 2, 1, 1);
    // full pipeline stalled three cycles, then resume
    setVec( 8, 1, 1, 1, 3, 0, 0,   0, 0, 1, 3, 0, 1);
    setVec( 9, 1, 1, 1, 3, 0, 0,   0, 0, 1, 3, 0, 1);
    setVec(10, 1, 1, 1, 3, 0, 0,   0, 0, 1, 3, 0, 1);
    setVec(11, 1, 1, 1, 3, 0, 1,   1, 0, 1, 3, 0, 1);
    setVec(12, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 1, 1);
    setVec(13, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 1);
    // two beats in flight, then flush with output handshake
    setVec(14, 1, 2, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    setVec(15, 0, 0, 1, 3, 0, 1,   0, 1, 0, 0, 0, 1);
    setVec(16, 1, 1, 1, 2, 1, 1,   0, 0, 1, 2, 0, 1);
    setVec(17, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    // rotation unchanged by flush: tie goes to requester 0
    setVec(18, 1, 1, 1, 2, 0, 1,   1, 0, 0, 0, 0, 0);
    setVec(19, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1);
    setVec(20, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 1);
    setVec(21, 0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 1);
    setVec(22, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);

    // Reset held: readys must stay low even with a valid request.
    ASYNCRESETN = 1'b0;
    req0_valid  = 1'b0;
    req0_data   = '0;
    req1_valid  = 1'b0;
    req1_data   = '0;
    flush       = 1'b0;
    out_ready   = 1'b1;
    @(negedge CLK);
    req0_valid = 1'b1;
    #2;
    checkOutput("reset req0_ready", -1, 32'(req0_ready), 32'd0);
    checkOutput("reset req1_ready", -1, 32'(req1_ready), 32'd0);
    checkOutput("reset out_valid",  -1, 32'(out_valid),  32'd0);
    checkOutput("reset busy",       -1, 32'(busy),       32'd0);
    checkOutput("reset out_data",   -1, 32'(out_data),   32'd0);
`ifdef PIPE_SEQ_CTRL_PERF_EN
    checkOutput("reset perf_stall", -1, 32'(perf_stall), 32'd0);
`endif
    req0_valid = 1'b0;
    #1 ASYNCRESETN = 1'b1;

    // Table-driven section.
    for (int i = 0; i < N_VECS; i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #2;
      checkOutput("req0_ready", i, 32'(req0_ready), 32'(vecs[i].e_r0r));
      checkOutput("req1_ready", i, 32'(req1_ready), 32'(vecs[i].e_r1r));
      checkOutput("out_valid",  i, 32'(out_valid),  32'(vecs[i].e_ov));
      checkOutput("busy",       i, 32'(busy),       32'(vecs[i].e_busy));
      if (vecs[i].e_ov) begin
        checkOutput("out_data", i, 32'(out_data), 32'(vecs[i].e_od));
        checkOutput("out_id",   i, 32'(out_id),   32'(vecs[i].e_oid));
      end
    end

`ifdef PIPE_SEQ_CTRL_PERF_EN
    // Six requester-0 beats, four requester-1 beats, four stalled cycles.
    checkOutput("perf_grant0 table", 100, 32'(perf_grant0), 32'd6);
    checkOutput("perf_grant1 table", 100, 32'(perf_grant1), 32'd4);
    checkOutput("perf_stall table",  100, 32'(perf_stall),  32'd4);
`endif

    // Long stall: one beat parked at the output with out_ready low.
    @(negedge CLK);
    req0_valid = 1'b1;
    req0_data  = 2'd1;
    req1_valid = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    #2;
    checkOutput("stall load req0_ready", 200, 32'(req0_ready), 32'd1);
    @(negedge CLK);
    req0_valid = 1'b0;
    @(negedge CLK);
    #2;
    checkOutput("stall out_valid", 201, 32'(out_valid), 32'd1);
    checkOutput("stall out_data",  201, 32'(out_data),  32'd1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (STALL_N) @(negedge CLK);
    #2;
    checkOutput("stall held out_data", 202, 32'(out_data),   32'd1);
    checkOutput("stall req0_ready",    202, 32'(req0_ready), 32'd0);
    checkOutput("stall req1_ready",    202, 32'(req1_ready), 32'd0);
`ifdef PIPE_SEQ_CTRL_PERF_EN
    checkOutput("perf_stall saturated", 202, 32'(perf_stall),  32'hFFFF);
    checkOutput("perf_grant0 final",    202, 32'(perf_grant0), 32'd7);
`endif

    // Async reset between edges: beat must vanish before the next edge.
    #1 ASYNCRESETN = 1'b0;
    #1;
    checkOutput("async out_valid",  300, 32'(out_valid),  32'd0);
    checkOutput("async busy",       300, 32'(busy),       32'd0);
    checkOutput("async req0_ready", 300, 32'(req0_ready), 32'd0);
`ifdef PIPE_SEQ_CTRL_PERF_EN
    checkOutput("async perf_stall", 300, 32'(perf_stall), 32'd0);
`endif

    // After release the first tie goes to requester 0 again.
    @(negedge CLK);
    #1 ASYNCRESETN = 1'b1;
    req0_data  = 2'd2;
    req1_data  = 2'd1;
    out_ready  = 1'b1;
    #1;
    checkOutput("post-reset req0_ready", 301, 32'(req0_ready), 32'd1);
    checkOutput("post-reset req1_ready", 301, 32'(req1_ready), 32'd0);
    @(negedge CLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge CLK);
    #2;
    checkOutput("post-reset out_valid", 302, 32'(out_valid), 32'd1);
    checkOutput("post-reset out_data",  302, 32'(out_data),  32'd2);
    checkOutput("post-reset out_id",    302, 32'(out_id),    32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 2, data width of each pipeline stage register.
REQ-002 Parameter: DEPTH, 2, number of register stages sequenced (legal range 1..8).
REQ-003 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: ASYNCRESETN  input  1  reset, asynchronous assert, active-low; synchronous release to CLK externally.
REQ-005 Port: req0_valid  input  1  requester 0 has a beat.
REQ-006 Port: req0_data  input  WIDTH  requester 0 beat payload.
REQ-007 Port: req0_ready  output  1  requester 0 beat accepted this cycle.
REQ-008 Port: req1_valid / req1_data / req1_ready  input / input / output  1 / WIDTH / 1  requester 1, same semantics as requester 0.
REQ-009 Port: flush  input  1  discard all in-flight beats.
REQ-010 Port: out_valid  output  1  last stage holds a beat.
REQ-011 Port: out_data  output  WIDTH  last-stage payload.
REQ-012 Port: out_id  output  1  requester index of last-stage beat.
REQ-013 Port: out_ready  input  1  downstream accepts beat.
REQ-014 Port: busy  output  1  OR of all stage valid bits.

Function
REQ-015 Each stage SHALL hold {valid, id, data}; stage DEPTH-1 SHALL drive out_valid/out_id/out_data directly (registered outputs).
REQ-016 advance = !(out_valid && !out_ready); on advance all stages SHALL shift one position and stage 0 SHALL load the accepted beat, or valid=0 if none accepted.
REQ-017 When !advance, all stages SHALL hold; no beat accepted (bubbles not collapsed).
REQ-018 Arbiter: 2-way round-robin on last_grant; single valid requester wins; both valid -> requester != last_grant wins.
REQ-019 reqN_ready = advance && !flush && grant==N; at most one ready high per cycle; ready may depend combinationally on valids.
REQ-020 last_grant SHALL update only on an accepted beat.
REQ-021 Latency: beat accepted in cycle N with no stalls SHALL appear on out_valid in cycle N+DEPTH, data and id unchanged.
REQ-022 Output beat transfers when out_valid && out_ready; out_data/out_id stable while out_valid && !out_ready.
REQ-023 flush: no acceptance that cycle; all stage valid bits SHALL be 0 after the edge; an output handshake in the same cycle still counts as delivered; last_grant unchanged.
REQ-024 Full pipeline with out_ready high SHALL sustain one accept and one deliver per cycle.

Reset
REQ-025 On ASYNCRESETN low: all stage valid/id/data = 0, out_valid=0, busy=0, last_grant=1 (requester 0 wins first tie), req0_ready/req1_ready combinationally 0.
REQ-026 Reset mid-operation SHALL drop all in-flight beats immediately, without waiting for CLK.

Configuration
REQ-027 Macro PIPE_SEQ_CTRL_PERF_EN defined: adds outputs perf_grant0, perf_grant1, perf_stall (16 bits each), counting accepted beats per requester and cycles with out_valid && !out_ready, saturating at 0xFFFF, reset to 0, unaffected by flush.
REQ-028 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Package pipe_seq_pkg SHALL hold REQ_ID_0/REQ_ID_1 constants, PERF_W=16, and the stage record typedef {valid, id, data}.
REQ-030 Sub-module pipe_seq_rr_arb SHALL implement the 2-way round-robin grant and last_grant register.

Verification
REQ-031 Reset, DEPTH=2: req0_valid=1 data=2'h1 at cycle 0 -> req0_ready=1 cycle 0; out_valid=1, out_data=2'h1, out_id=0 in cycle 2.
REQ-032 Both valid for 4 cycles, out_ready=1 -> grants 0,1,0,1; out_id sequence 0,1,0,1 starting cycle 2.
REQ-033 Pipeline full, out_ready=0 for 3 cycles -> both readys 0, out_data held; out_ready=1 -> resumes one beat/cycle, no loss or duplication.
REQ-034 Two beats in flight, flush=1 one cycle -> busy=0 and out_valid=0 next cycle; no ready high during flush cycle.
REQ-035 ASYNCRESETN low between edges with beats in flight -> out_valid and busy drop before next CLK edge.
REQ-036 PERF_EN: 3 req0 beats, 2 req1 beats, 4 stall cycles -> perf_grant0=3, perf_grant1=2, perf_stall=4; 70000 stall cycles -> perf_stall=0xFFFF.
